// File: rtl/hall_commutation_timer.sv
// hall_commutation_timer
// Synchronizes and debounces the raw hall sensor levels, decodes the rotor
// sector, measures the clock count spent in each sector and schedules a
// delayed one-cycle commutation strobe from the last measured sector period.
module hall_commutation_timer #(
    parameter int DEBOUNCE    = 4,   // stable samples before HS updates (1..15)
    parameter int CNT_W       = 16,  // period / delay counter width
    parameter int DELAY_SHIFT = 2    // commutation delay = period >> DELAY_SHIFT
) (
    input  logic             controlCLK,
    input  logic             reset,
    input  logic [2:0]       hall_in,
    output logic [2:0]       HS,
    output logic [2:0]       rotateState,
    output logic             direction,
    output logic [9:0]       HSCounter,
    output logic [CNT_W-1:0] counter_per_cycle,
    output logic [CNT_W-1:0] oldCounter_per_cycle,
    output logic [CNT_W-1:0] delayAngleCounter,
    output logic             commutate,
    output logic             stalled,
    output logic             hall_fault
);

    localparam int               DB_W         = 4;
    localparam logic [DB_W-1:0]  DB_TARGET    = DB_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] CNT_NEAR_MAX = CNT_MAX - 1'b1;
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [2:0]       SECTOR_NONE  = 3'd7;

    // Hall code {C,B,A} to sector; 000 and 111 are not physical positions.
    function automatic logic [2:0] decode_sector(input logic [2:0] code);
        case (code)
            3'b001:  decode_sector = 3'd0;
            3'b011:  decode_sector = 3'd1;
            3'b010:  decode_sector = 3'd2;
            3'b110:  decode_sector = 3'd3;
            3'b100:  decode_sector = 3'd4;
            3'b101:  decode_sector = 3'd5;
            default: decode_sector = SECTOR_NONE;
        endcase
    endfunction

    // Input path state
    logic [2:0]       sync1_q, sync2_q;
    logic [2:0]       cand_q;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [2:0]       hs_q, hs_d;

    // Sector tracking state
    logic             known_q;
    logic [2:0]       last_sector_q;
    logic             direction_q;
    logic             fault_q;

    // Timing state
    logic [9:0]       hs_count_q, hs_count_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] old_period_q, old_period_d;
    logic [CNT_W-1:0] delay_q, delay_d;
    logic             commutate_q, commutate_d;
    logic             stalled_q, stalled_d;

    // Decoded sector and edge classification
    logic [2:0]       sector;
    logic             sector_valid;
    logic             edge_evt;
    logic             step_fwd, step_rev;
    logic [CNT_W-1:0] new_delay;

    // Debounce: count consecutive identical synchronized samples, including the current one.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
        db_cnt_d = 4'd1;
        hs_d     = hs_q;
        if (sync2_q == cand_q) begin
            db_cnt_d = (db_cnt_q >= DB_TARGET) ? db_cnt_q : db_cnt_q + 1'b1;
        end
        if (db_cnt_d >= DB_TARGET) begin
            hs_d = sync2_q;
        end
    end

    // 2-FF synchronizer followed by the debounce filter.
    always_ff @(posedge controlCLK) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            db_cnt_q <= '0;
            hs_q     <= '0;
        end else begin
            sync1_q  <= hall_in;
            sync2_q  <= sync1_q;
            cand_q   <= sync2_q;
            db_cnt_q <= db_cnt_d;
            hs_q     <= hs_d;
        end
    end

    // Sector decode and edge detection against the last valid sector.
    always_comb begin
        sector       = decode_sector(hs_q);
        sector_valid = (sector != SECTOR_NONE);
        edge_evt     = sector_valid && known_q && (sector != last_sector_q);
        step_fwd     = (last_sector_q == 3'd5) ? (sector == 3'd0) : (sector == last_sector_q + 3'd1);
        step_rev     = (last_sector_q == 3'd0) ? (sector == 3'd5) : (sector == last_sector_q - 3'd1);
    end

    // Track last valid sector, rotation direction and the sticky jump fault.
    always_ff @(posedge controlCLK) begin
        if (reset) begin
            known_q       <= 1'b0;
            last_sector_q <= '0;
            direction_q   <= 1'b1;
            fault_q       <= 1'b0;
        end else begin
            if (sector_valid) begin
                known_q       <= 1'b1;
                last_sector_q <= sector;
            end
            if (edge_evt) begin
                if (step_fwd) begin
                    direction_q <= 1'b1;
                end else if (step_rev) begin
                    direction_q <= 1'b0;
                end
                fault_q <= !(step_fwd || step_rev);
            end
        end
    end

    // Period measurement, stall detection and commutation delay scheduling.
    always_comb begin
        period_d     = period_q;
        old_period_d = old_period_q;
        delay_d      = delay_q;
        commutate_d  = 1'b0;
        stalled_d    = stalled_q;
        hs_count_d   = hs_count_q;
        new_delay    = period_q >> DELAY_SHIFT;
        if (edge_evt) begin
            old_period_d = stalled_q ? CNT_MAX : period_q;
            period_d     = '0;
            hs_count_d   = hs_count_q + 10'd1;
            if (stalled_q) begin
                // Restarting from standstill: commutate immediately.
                stalled_d   = 1'b0;
                delay_d     = '0;
                commutate_d = 1'b1;
            end else begin
                // A still-pending strobe is flushed now rather than dropped.
                delay_d     = new_delay;
                commutate_d = (delay_q != '0) || (new_delay == '0);
            end
        end else if (period_q >= CNT_NEAR_MAX) begin
            // Motor stopped: hold the count and abandon any scheduled strobe.
            period_d  = CNT_MAX;
            stalled_d = 1'b1;
            delay_d   = '0;
        end else begin
            period_d = period_q + 1'b1;
            if (delay_q != '0) begin
                delay_d     = delay_q - 1'b1;
                commutate_d = (delay_q == CNT_ONE);
            end
        end
    end

    // Timing registers.
    always_ff @(posedge controlCLK) begin
        if (reset) begin
            hs_count_q   <= '0;
            period_q     <= '0;
            old_period_q <= '0;
            delay_q      <= '0;
            commutate_q  <= 1'b0;
            stalled_q    <= 1'b1;
        end else begin
            hs_count_q   <= hs_count_d;
            period_q     <= period_d;
            old_period_q <= old_period_d;
            delay_q      <= delay_d;
            commutate_q  <= commutate_d;
            stalled_q    <= stalled_d;
        end
    end

    // Output mapping; an invalid code only counts as a fault once a sector has been seen.
    always_comb begin
        HS                   = hs_q;
        rotateState          = sector;
        direction            = direction_q;
        HSCounter            = hs_count_q;
        counter_per_cycle    = period_q;
        oldCounter_per_cycle = old_period_q;
        delayAngleCounter    = delay_q;
        commutate            = commutate_q;
        stalled              = stalled_q;
        hall_fault           = fault_q | (known_q & ~sector_valid);
    end

endmodule

// File: tb/tb_hall_commutation_timer.sv
// Directed bench for hall_commutation_timer. Cycle marks Pn in the comments
// count rising edges after the last reset edge (P0); outputs are sampled 1 ns
// after each rising edge and hall_in is driven at the same point.
module tb_hall_commutation_timer;

    logic        clk;
    logic        reset;
    logic [2:0]  hall_in;
    logic [2:0]  HS;
    logic [2:0]  rotateState;
    logic        direction;
    logic [9:0]  HSCounter;
    logic [15:0] counter_per_cycle;
    logic [15:0] oldCounter_per_cycle;
    logic [15:0] delayAngleCounter;
    logic        commutate;
    logic        stalled;
    logic        hall_fault;

    int vectors     = 0;
    int miscompares = 0;
    int comm_cnt    = 0;

    hall_commutation_timer #(
        .DEBOUNCE    (4),
        .CNT_W       (16),
        .DELAY_SHIFT (2)
    ) dut (
        .controlCLK           (clk),
        .reset                (reset),
        .hall_in              (hall_in),
        .HS                   (HS),
        .rotateState          (rotateState),
        .direction            (direction),
        .HSCounter            (HSCounter),
        .counter_per_cycle    (counter_per_cycle),
        .oldCounter_per_cycle (oldCounter_per_cycle),
        .delayAngleCounter    (delayAngleCounter),
        .commutate            (commutate),
        .stalled              (stalled),
        .hall_fault           (hall_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count commutation strobes mid-cycle.
    always @(negedge clk) begin
        if (commutate === 1'b1) comm_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset   = 1'b1;
        hall_in = 3'b000;
        tick(3);                                   // P0
        check("rst_HS",        HS, 0);
        check("rst_rotate",    rotateState, 7);
        check("rst_dir",       direction, 1);
        check("rst_hscnt",     HSCounter, 0);
        check("rst_cnt",       counter_per_cycle, 0);
        check("rst_old",       oldCounter_per_cycle, 0);
        check("rst_delay",     delayAngleCounter, 0);
        check("rst_comm",      commutate, 0);
        check("rst_stalled",   stalled, 1);
        check("rst_fault",     hall_fault, 0);

        // T1: first valid code after reset, 2+DEBOUNCE latency.
        reset   = 1'b0;
        hall_in = 3'b001;
        tick(5);                                   // P5
        check("t1_HS_p5",      HS, 0);
        tick(1);                                   // P6
        check("t1_HS_p6",      HS, 3'b001);
        check("t1_rotate",     rotateState, 0);
        tick(4);                                   // P10
        check("t1_hscnt",      HSCounter, 0);
        check("t1_stalled",    stalled, 1);
        check("t1_cnt",        counter_per_cycle, 10);
        check("t1_comm_cnt",   comm_cnt, 0);

        // T2: restart from stall, edge processed at P407.
        tick(390);                                 // P400
        hall_in = 3'b011;
        tick(7);                                   // P407
        check("t2_old_max",    oldCounter_per_cycle, 65535);
        check("t2_stalled",    stalled, 0);
        check("t2_comm",       commutate, 1);
        check("t2_hscnt",      HSCounter, 1);
        check("t2_dir",        direction, 1);
        check("t2_cnt0",       counter_per_cycle, 0);
        check("t2_rotate",     rotateState, 1);
        tick(1);                                   // P408
        check("t2_comm_off",   commutate, 0);
        check("t2_cnt1",       counter_per_cycle, 1);
        tick(393);                                 // P801
        hall_in = 3'b010;
        tick(7);                                   // P808
        check("t2_old400",     oldCounter_per_cycle, 400);
        check("t2_delay100",   delayAngleCounter, 100);
        check("t2_hscnt2",     HSCounter, 2);
        check("t2_comm_load",  commutate, 0);
        tick(99);                                  // P907
        check("t2_delay1",     delayAngleCounter, 1);
        check("t2_comm_early", commutate, 0);
        tick(1);                                   // P908
        check("t2_comm_fire",  commutate, 1);
        check("t2_delay0",     delayAngleCounter, 0);
        tick(1);                                   // P909
        check("t2_comm_once",  commutate, 0);
        check("t2_comm_cnt",   comm_cnt, 2);

        // T3: 3-cycle glitch never reaches HS.
        hall_in = 3'b110;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("t3_HS_glitch", HS, 3'b010);
        end                                        // P912
        hall_in = 3'b010;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("t3_HS_after", HS, 3'b010);
        end                                        // P922
        check("t3_hscnt",      HSCounter, 2);
        check("t3_cnt",        counter_per_cycle, 114);

        // T4: invalid code, then return to the same sector.
        hall_in = 3'b000;
        tick(6);                                   // P928
        check("t4_rotate7",    rotateState, 7);
        check("t4_fault",      hall_fault, 1);
        check("t4_cnt",        counter_per_cycle, 120);
        tick(5);                                   // P933
        check("t4_cnt_run",    counter_per_cycle, 125);
        hall_in = 3'b010;
        tick(6);                                   // P939
        check("t4_rotate2",    rotateState, 2);
        check("t4_fault_clr",  hall_fault, 0);
        tick(1);                                   // P940
        check("t4_no_edge",    HSCounter, 2);
        check("t4_cnt2",       counter_per_cycle, 132);
        check("t4_comm_cnt",   comm_cnt, 2);

        // T5: reverse step, non-adjacent jump, recovery.
        hall_in = 3'b011;
        tick(7);                                   // P947
        check("t5_rev_dir",    direction, 0);
        check("t5_rev_old",    oldCounter_per_cycle, 138);
        check("t5_rev_delay",  delayAngleCounter, 34);
        check("t5_rev_hscnt",  HSCounter, 3);
        tick(34);                                  // P981
        check("t5_comm34",     commutate, 1);
        tick(1);                                   // P982
        hall_in = 3'b100;
        tick(7);                                   // P989
        check("t5_jump_fault", hall_fault, 1);
        check("t5_jump_dir",   direction, 0);
        check("t5_jump_hscnt", HSCounter, 4);
        check("t5_jump_old",   oldCounter_per_cycle, 41);
        check("t5_jump_delay", delayAngleCounter, 10);
        check("t5_jump_rot",   rotateState, 4);
        tick(10);                                  // P999
        check("t5_comm10",     commutate, 1);
        tick(1);                                   // P1000
        check("t5_sticky",     hall_fault, 1);
        hall_in = 3'b101;
        tick(7);                                   // P1007
        check("t5_adj_fault",  hall_fault, 0);
        check("t5_adj_dir",    direction, 1);
        check("t5_adj_old",    oldCounter_per_cycle, 17);
        check("t5_adj_delay",  delayAngleCounter, 4);
        check("t5_adj_hscnt",  HSCounter, 5);

        // T6: edge while a 100-cycle delay is pending.
        tick(394);                                 // P1401
        hall_in = 3'b001;
        tick(7);                                   // P1408
        check("t6_old400",     oldCounter_per_cycle, 400);
        check("t6_delay100",   delayAngleCounter, 100);
        check("t6_rotate0",    rotateState, 0);
        tick(34);                                  // P1442
        hall_in = 3'b011;
        tick(7);                                   // P1449
        check("t6_flush_comm", commutate, 1);
        check("t6_reload10",   delayAngleCounter, 10);
        check("t6_old40",      oldCounter_per_cycle, 40);
        check("t6_hscnt",      HSCounter, 7);
        tick(1);                                   // P1450
        check("t6_comm_off",   commutate, 0);
        check("t6_delay9",     delayAngleCounter, 9);
        tick(9);                                   // P1459
        check("t6_comm_new",   commutate, 1);
        tick(1);                                   // P1460
        check("t6_comm_cnt",   comm_cnt, 7);

        // Stall: no edge until the period counter saturates.
        tick(65523);                               // P66983
        check("st_cnt_pre",    counter_per_cycle, 65534);
        check("st_stalled_pre", stalled, 0);
        tick(1);                                   // P66984
        check("st_cnt_max",    counter_per_cycle, 65535);
        check("st_stalled",    stalled, 1);
        tick(1);                                   // P66985
        check("st_cnt_hold",   counter_per_cycle, 65535);
        hall_in = 3'b010;
        tick(7);                                   // P66992
        check("st_old_max",    oldCounter_per_cycle, 65535);
        check("st_restart",    stalled, 0);
        check("st_comm",       commutate, 1);
        check("st_hscnt",      HSCounter, 8);

        // Reset during a pending countdown suppresses the strobe.
        tick(101);                                 // P67093
        hall_in = 3'b110;
        tick(7);                                   // P67100
        check("rc_delay26",    delayAngleCounter, 26);
        check("rc_old107",     oldCounter_per_cycle, 107);
        tick(5);                                   // P67105
        check("rc_delay21",    delayAngleCounter, 21);
        reset = 1'b1;
        tick(1);
        check("rc_delay_rst",  delayAngleCounter, 0);
        check("rc_hscnt_rst",  HSCounter, 0);
        check("rc_stalled",    stalled, 1);
        check("rc_HS_rst",     HS, 0);
        reset = 1'b0;
        tick(40);
        check("rc_comm_cnt",   comm_cnt, 8);
        check("rc_hscnt",      HSCounter, 0);
        check("rc_rotate",     rotateState, 3);
        check("rc_cnt",        counter_per_cycle, 40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
